// File: rtl/led_array_scanner.sv
// ---------------------------------------------------------------------------
// led_array_scanner
//
// Column-scan sequencer that sits in front of the LED array driver.
//
// Frames
//   Whole N*N frames arrive from the game engine over a valid/ready handshake.
//   An accepted frame lands in a shadow buffer. The shadow buffer is promoted
//   to the display buffer only when the last column of a frame finishes, so
//   the driver never shows a torn frame.
//
// Column scan
//   Each column gets BLANK_CYCLES with ena low, then DWELL_CYCLES of drive.
//   The column index x advances on the edge that ends a drive period, which
//   is also the edge where ena falls. The driver therefore never sees x move
//   while ena is high. The one exception is BLANK_CYCLES=0, where drive
//   periods run back to back.
//
// Optional feature (compile-time macro LED_SCAN_BRIGHTNESS_EN)
//   Adds a 4-bit brightness input. During drive, ena is high only for the
//   first (brightness+1)/16 of the dwell. Timing of x and frame_done does not
//   change.
//
// Parameters
//   N             grid size, 2..8
//   DWELL_CYCLES  drive cycles per column, a multiple of 16 and >= 16
//   BLANK_CYCLES  blanking cycles before each column, 0 allowed
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   cells_in     in   N*N new frame, bit i*N+j = row i, column j
//   cells_valid  in   cells_in holds a frame
//   cells_ready  out  shadow buffer empty, a frame can be accepted
//   brightness   in   4-bit level (only with LED_SCAN_BRIGHTNESS_EN)
//   ena          out  driver enable
//   x            out  active column index
//   cells        out  display buffer fed to the driver
//   frame_done   out  one-cycle pulse after the last column of a frame
// ---------------------------------------------------------------------------
module led_array_scanner #(
    parameter int N            = 8,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*N-1:0]         cells_in,
    input  logic                   cells_valid,
    output logic                   cells_ready,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [3:0]             brightness,
`endif
    output logic                   ena,
    output logic [$clog2(N)-1:0]   x,
    output logic [N*N-1:0]         cells,
    output logic                   frame_done
);

    // -----------------------------------------------------------------------
    // Parameter legality
    // -----------------------------------------------------------------------
    if (N < 2 || N > 8) begin : g_bad_n
        $error("led_array_scanner: N=%0d outside legal range 2..8", N);
    end
    if (DWELL_CYCLES < 16 || (DWELL_CYCLES % 16) != 0) begin : g_bad_dwell
        $error("led_array_scanner: DWELL_CYCLES=%0d must be a multiple of 16 and >= 16",
               DWELL_CYCLES);
    end
    if (BLANK_CYCLES < 0) begin : g_bad_blank
        $error("led_array_scanner: BLANK_CYCLES=%0d must not be negative", BLANK_CYCLES);
    end

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int XW      = $clog2(N);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    // The zero-gap case never compares against this value. The guard only
    // keeps the constant well-formed.
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [XW-1:0]    X_LAST     = XW'(N - 1);
    localparam logic             NO_GAP     = (BLANK_CYCLES == 0);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XW-1:0]      x_q;
    logic               ena_q;
    logic               frame_done_q;
    logic [N*N-1:0]     cells_q;
    logic [N*N-1:0]     shadow_q;
    logic               shadow_full_q;

    // Brightness level in effect. Without the feature it is pinned to full
    // scale, so the drive window covers the whole dwell.
    logic [3:0]         level;
`ifdef LED_SCAN_BRIGHTNESS_EN
    assign level = brightness;
`else
    assign level = 4'hF;
`endif

    // True when a drive cycle whose counter value is cnt_next falls inside
    // the lit part of the dwell. The lit part is (level+1) sixteenths of the
    // dwell.
    function automatic logic drive_window(input logic [CNT_W-1:0] cnt_next,
                                          input logic [3:0]       lvl);
        int lim;
        lim = (int'(lvl) + 1) * (DWELL_CYCLES / 16);
        return int'(cnt_next) < lim;
    endfunction

    // A frame transfers only into an empty shadow buffer. Promotion needs a
    // full buffer, so an accept and a promotion can never fall on the same
    // edge.
    logic accept;
    assign accept = cells_valid && !shadow_full_q;

    // -----------------------------------------------------------------------
    // Scan FSM, handshake and buffers
    //
    // ena is registered. Every branch sets it from the state and counter that
    // take effect on the same edge, so ena lines up exactly with the DRIVE
    // state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BLANK;
            cnt_q         <= '0;
            x_q           <= '0;
            ena_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            cells_q       <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (accept) begin
                shadow_q      <= cells_in;
                shadow_full_q <= 1'b1;
            end

            case (state_q)
                S_BLANK: begin
                    if (NO_GAP || cnt_q == BLANK_LAST) begin
                        state_q <= S_DRIVE;
                        cnt_q   <= '0;
                        ena_q   <= drive_window('0, level);
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        ena_q   <= 1'b0;
                    end
                end

                S_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_q <= '0;
                        // The column advances on the edge where ena drops.
                        if (x_q == X_LAST) begin
                            x_q          <= '0;
                            frame_done_q <= 1'b1;
                            // Frame boundary: the only point where the
                            // displayed frame may change.
                            if (shadow_full_q) begin
                                cells_q       <= shadow_q;
                                shadow_full_q <= 1'b0;
                            end
                        end else begin
                            x_q <= x_q + 1'b1;
                        end

                        if (NO_GAP) begin
                            state_q <= S_DRIVE;
                            ena_q   <= drive_window('0, level);
                        end else begin
                            state_q <= S_BLANK;
                            ena_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        ena_q <= drive_window(cnt_q + 1'b1, level);
                    end
                end

                default: begin
                    state_q <= S_BLANK;
                    cnt_q   <= '0;
                    ena_q   <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cells_ready = !shadow_full_q;
    assign ena         = ena_q;
    assign x           = x_q;
    assign cells       = cells_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_array_scanner.sv
// ---------------------------------------------------------------------------
// tb_led_array_scanner
//
// Bench for led_array_scanner with N=8, DWELL_CYCLES=16, BLANK_CYCLES=2.
// One frame lasts 144 cycles.
//
// The reference model tracks t, the number of clock edges since reset ended.
// It derives column, enable and frame boundaries from t with plain
// arithmetic. It also keeps a displayed frame and a pending frame.
// ---------------------------------------------------------------------------
module tb_led_array_scanner;

    localparam int N  = 8;
    localparam int D  = 16;
    localparam int B  = 2;
    localparam int P  = D + B;
    localparam int F  = N * P;

    logic        clk;
    logic        rst;
    logic [63:0] cells_in;
    logic        cells_valid;
    logic        cells_ready;
    logic        ena;
    logic [2:0]  x;
    logic [63:0] cells;
    logic        frame_done;
    logic [3:0]  bri;

    led_array_scanner #(
        .N            (N),
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cells_in    (cells_in),
        .cells_valid (cells_valid),
        .cells_ready (cells_ready),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .brightness  (bri),
`endif
        .ena         (ena),
        .x           (x),
        .cells       (cells),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_t;
    logic [63:0] m_disp;
    logic [63:0] m_pend;
    bit          m_full;
    bit          m_ena;
    int          m_x;
    bit          m_fd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", nm, m_t, act, exp);
        end
    endtask

    // Advance the model across one clock edge, using the inputs present
    // before that edge.
    task automatic model_edge();
        bit acc;
        int pos;
        int lim;
        if (rst) begin
            m_t    = 0;
            m_disp = '0;
            m_full = 0;
        end else begin
            acc = cells_valid && !m_full;
            m_t++;
            if (m_t % F == 0 && m_full) begin
                m_disp = m_pend;
                m_full = 0;
            end
            if (acc) begin
                m_pend = cells_in;
                m_full = 1;
            end
        end
        pos   = m_t % P;
        lim   = (int'(bri) + 1) * (D / 16);
        m_x   = (m_t / P) % N;
        m_ena = (pos >= B) && ((pos - B) < lim);
        m_fd  = (m_t > 0) && (m_t % F == 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("ena",   64'(ena),         64'(m_ena));
        chk("x",     64'(x),           64'(m_x));
        chk("ready", 64'(cells_ready), 64'(!m_full));
        chk("fdone", 64'(frame_done),  64'(m_fd));
        chk("cells", cells,            m_disp);
    endtask

    typedef struct {
        bit          rst;
        bit          vld;
        logic [63:0] din;
        int          adv;
        bit          e_ena;
        int          e_x;
        bit          e_rdy;
        bit          e_fd;
        logic [63:0] e_cells;
    } vec_t;

    localparam logic [63:0] FA = 64'h8142241818244281;
    localparam logic [63:0] FB = 64'h0123456789ABCDEF;
    localparam logic [63:0] FC = 64'hFEDCBA9876543210;
    localparam logic [63:0] FD = 64'hDEADBEEFCAFEF00D;

    vec_t vt[12];

    initial begin
        int n;
        int cnt_hi;

        rst         = 1'b1;
        cells_valid = 1'b0;
        cells_in    = '0;
        bri         = 4'hF;

        // Reset, start-up timing, a single accept and the first boundary.
        // Each row gives the inputs, the cycles to advance, and the expected
        // outputs afterwards.
        vt[0]  = '{1, 0, 64'h0,  3, 0, 0, 1, 0, 64'h0};   // held in reset
        vt[1]  = '{0, 0, 64'h0,  1, 0, 0, 1, 0, 64'h0};   // t=1 still blank
        vt[2]  = '{0, 0, 64'h0,  1, 1, 0, 1, 0, 64'h0};   // t=2 ena rises
        vt[3]  = '{0, 0, 64'h0, 15, 1, 0, 1, 0, 64'h0};   // t=17 last drive
        vt[4]  = '{0, 0, 64'h0,  1, 0, 1, 1, 0, 64'h0};   // t=18 x steps, blank
        vt[5]  = '{0, 0, 64'h0,  2, 1, 1, 1, 0, 64'h0};   // t=20 drive col 1
        vt[6]  = '{0, 0, 64'h0, 10, 1, 1, 1, 0, 64'h0};   // t=30
        vt[7]  = '{0, 1, FA,     1, 1, 1, 0, 0, 64'h0};   // t=31 accepted
        vt[8]  = '{0, 0, 64'h0,112, 1, 7, 0, 0, 64'h0};   // t=143 last drive
        vt[9]  = '{0, 0, 64'h0,  1, 0, 0, 1, 1, FA};      // t=144 promoted
        vt[10] = '{0, 0, 64'h0,  1, 0, 0, 1, 0, FA};      // t=145 pulse over
        vt[11] = '{0, 0, 64'h0,143, 0, 0, 1, 1, FA};      // t=288 next frame

        for (int i = 0; i < 12; i++) begin
            rst         = vt[i].rst;
            cells_valid = vt[i].vld;
            cells_in    = vt[i].din;
            for (int k = 0; k < vt[i].adv; k++) step();
            chk($sformatf("vec%0d_ena", i),   64'(ena),         64'(vt[i].e_ena));
            chk($sformatf("vec%0d_x", i),     64'(x),           64'(vt[i].e_x));
            chk($sformatf("vec%0d_ready", i), 64'(cells_ready), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d_fdone", i), 64'(frame_done),  64'(vt[i].e_fd));
            chk($sformatf("vec%0d_cells", i), cells,            vt[i].e_cells);
        end
        cells_valid = 1'b0;

        // A second frame held valid while ready is low is captured only after
        // the promotion that frees the shadow buffer.
        cells_valid = 1'b1;
        cells_in    = FB;
        step();                                     // t=289, FB accepted
        chk("hold_ready_low", 64'(cells_ready), 64'(0));
        cells_in = FC;                              // held while not ready
        n = 0;
        while (m_t < 431 && n < 400) begin step(); n++; end
        chk("hold_t431", 64'(m_t), 64'(431));
        chk("hold_cells_old", cells, FA);
        step();                                     // t=432, promotion
        chk("hold_promoted", cells, FB);
        chk("hold_ready_back", 64'(cells_ready), 64'(1));
        step();                                     // t=433, FC captured
        chk("hold_captured", 64'(cells_ready), 64'(0));
        cells_valid = 1'b0;
        n = 0;
        while (m_t < 576 && n < 400) begin step(); n++; end
        chk("hold_shown", cells, FC);

        // Reset in the middle of column 5 with a frame pending.
        cells_valid = 1'b1;
        cells_in    = FD;
        step();                                     // t=577, FD pending
        cells_valid = 1'b0;
        n = 0;
        while (m_t < 670 && n < 400) begin step(); n++; end
        chk("rst_pre_x", 64'(x), 64'(5));
        chk("rst_pre_ena", 64'(ena), 64'(1));
        chk("rst_pre_ready", 64'(cells_ready), 64'(0));
        rst = 1'b1;
        step();
        chk("rst_ena", 64'(ena), 64'(0));
        chk("rst_x", 64'(x), 64'(0));
        chk("rst_cells", cells, 64'h0);
        chk("rst_ready", 64'(cells_ready), 64'(1));
        chk("rst_fdone", 64'(frame_done), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < F; k++) step();
        chk("rst_discard_fd", 64'(frame_done), 64'(1));
        chk("rst_discard_cells", cells, 64'h0);

`ifdef LED_SCAN_BRIGHTNESS_EN
        // Dimmed drive: brightness 3 lights 4 of 16 drive cycles per column.
        rst = 1'b1;
        bri = 4'd3;
        step();
        rst = 1'b0;
        cnt_hi = 0;
        for (int k = 0; k < P; k++) begin step(); cnt_hi += int'(ena); end
        chk("bri3_on_cycles", 64'(cnt_hi), 64'(4));
        bri = 4'd15;
        cnt_hi = 0;
        for (int k = 0; k < P; k++) begin step(); cnt_hi += int'(ena); end
        chk("bri15_on_cycles", 64'(cnt_hi), 64'(16));
`else
        cnt_hi = 0;
        for (int k = 0; k < P; k++) begin step(); cnt_hi += int'(ena); end
        chk("full_on_cycles", 64'(cnt_hi), 64'(16));
`endif

        // Randomized traffic, with occasional resets and, when the feature
        // is built in, brightness changes.
        for (int k = 0; k < 1500; k++) begin
            rst         = ($urandom_range(0, 399) == 0);
            cells_valid = ($urandom_range(0, 3) == 0);
            cells_in    = {$urandom, $urandom};
`ifdef LED_SCAN_BRIGHTNESS_EN
            if ($urandom_range(0, 49) == 0) bri = 4'($urandom_range(0, 15));
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
